soc_cpu_cpu_debug_mem_arbiter: RTL and testbench

//  Owns the single port of the CPU's on-chip debug RAM (OCI RAM). Shares it between two requesters:

---
 rtl/soc_cpu_cpu_debug_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_soc_cpu_cpu_debug_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_cpu_cpu_debug_mem_arbiter.sv
// Shares the single OCI debug RAM port between JTAG debug commands and the CPU-side Avalon slave.
// Latency: JTAG read result 4 cycles after the strobe when uncontended; Avalon read data 1 cycle after accept.
// Backpressure: Avalon is stalled with av_waitrequest; an overlapping JTAG strobe is dropped and flagged on monitor_error.
module soc_cpu_cpu_debug_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic              av_waitrequest,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              jtag_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_J_ACC = 3'd1,
    S_J_CAP = 3'd2,
    S_C_ACC = 3'd3,
    S_C_CAP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic              pend_q, pend_d;
  logic              pend_rd_q, pend_rd_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic [DATA_W-1:0] mondreg_q, mondreg_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  // 1 when JTAG owned the RAM most recently; reset to the CPU side so JTAG wins the first tie.
  logic              last_jtag_q, last_jtag_d;

  logic              av_req;
  logic              jtag_strobe;
  logic              busy;
  logic              unused_jdo;

  // jdo bits outside the address, read flag and write data fields carry nothing for this block.
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign av_req      = av_read | av_write;
  assign jtag_strobe = take_action_ocimem_a | take_action_ocimem_b;
  assign busy        = pend_q | (state_q == S_J_ACC) | (state_q == S_J_CAP);

  assign jtag_busy        = busy;
  assign av_waitrequest   = av_req & (state_q != S_C_ACC);
  assign av_readdatavalid = (state_q == S_C_CAP);
  assign av_readdata      = ram_rdata;
  assign MonDReg          = mondreg_q;
  assign monitor_ready    = rdy_q;
  assign monitor_error    = err_q;

  // Arbitration FSM, RAM port mux and JTAG command decode.
  always_comb begin
    state_d     = state_q;
    jaddr_d     = jaddr_q;
    pend_d      = pend_q;
    pend_rd_d   = pend_rd_q;
    wbuf_d      = wbuf_q;
    mondreg_d   = mondreg_q;
    rdy_d       = rdy_q;
    err_d       = err_q;
    last_jtag_d = last_jtag_q;
    ram_addr    = jaddr_q;
    ram_wren    = 1'b0;
    ram_wdata   = wbuf_q;

    case (state_q)
      S_IDLE: begin
        // On a tie the side that did not own the RAM last goes first.
        if (pend_q && (!av_req || !last_jtag_q)) begin
          state_d     = S_J_ACC;
          last_jtag_d = 1'b1;
        end else if (av_req) begin
          state_d     = S_C_ACC;
          last_jtag_d = 1'b0;
        end
      end
      S_J_ACC: begin
        ram_addr  = jaddr_q;
        ram_wren  = ~pend_rd_q;
        ram_wdata = wbuf_q;
        pend_d    = 1'b0;
        if (pend_rd_q) begin
          state_d = S_J_CAP;
        end else begin
          jaddr_d = jaddr_q + 1'b1;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_J_CAP: begin
        mondreg_d = ram_rdata;
        rdy_d     = 1'b1;
        jaddr_d   = jaddr_q + 1'b1;
        state_d   = S_IDLE;
      end
      S_C_ACC: begin
        ram_addr  = av_address;
        ram_wren  = av_write;
        ram_wdata = av_writedata;
        // A write takes precedence if a master ever drives both strobes.
        if (!av_write && av_read) begin
          state_d = S_C_CAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_C_CAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear first so that a simultaneous overrun keeps the error flag set.
    if (take_no_action_ocimem_a) begin
      err_d = 1'b0;
    end

    // A new command is only taken while nothing is queued or running, so it never
    // collides with the FSM's own updates to jaddr/pend above.
    if (jtag_strobe) begin
      if (busy) begin
        err_d = 1'b1;
      end else begin
        rdy_d = 1'b0;
        if (take_action_ocimem_a) begin
          jaddr_d = jdo[ADDR_W+16:17];
          if (jdo[35]) begin
            pend_d    = 1'b1;
            pend_rd_d = 1'b1;
          end
        end else begin
          wbuf_d    = DATA_W'(jdo[34:3]);
          pend_d    = 1'b1;
          pend_rd_d = 1'b0;
        end
      end
    end
  end

  // State and JTAG-side registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      jaddr_q     <= '0;
      pend_q      <= 1'b0;
      pend_rd_q   <= 1'b0;
      wbuf_q      <= '0;
      mondreg_q   <= '0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
      last_jtag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      jaddr_q     <= jaddr_d;
      pend_q      <= pend_d;
      pend_rd_q   <= pend_rd_d;
      wbuf_q      <= wbuf_d;
      mondreg_q   <= mondreg_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
      last_jtag_q <= last_jtag_d;
    end
  end

endmodule

// File: tb/tb_soc_cpu_cpu_debug_mem_arbiter.sv
module tb_soc_cpu_cpu_debug_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [37:0]   jdo;
  logic          ta_a, ta_b, tna_a;
  logic [AW-1:0] av_address;
  logic          av_read, av_write;
  logic [DW-1:0] av_writedata;
  logic          av_waitrequest;
  logic [DW-1:0] av_readdata;
  logic          av_readdatavalid;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] MonDReg;
  logic          monitor_ready, monitor_error, jtag_busy;

  always #5 clk = ~clk;

  soc_cpu_cpu_debug_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b), .take_no_action_ocimem_a(tna_a),
    .av_address(av_address), .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .jtag_busy(jtag_busy)
  );

  // Environment: synchronous RAM with one cycle of read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: RAM contents, JTAG address pointer and last JTAG read value.
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] m_jaddr;
  logic [DW-1:0] m_mon;
  logic [DW-1:0] exp_av_q[$];
  logic [DW-1:0] exp_mon_q[$];

  int checks = 0;
  int errors = 0;
  bit rdy_prev = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every Avalon read return and every JTAG completion against the queues.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!reset_n) begin
      rdy_prev = 1'b0;
    end else begin
      if (av_readdatavalid) begin
        if (exp_av_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL av_unexpected: got readdatavalid data 0x%0h expected none", av_readdata);
        end else begin
          e = exp_av_q.pop_front();
          check("av_readdata", av_readdata, e);
        end
      end
      if (monitor_ready && !rdy_prev) begin
        if (exp_mon_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon_unexpected: got monitor_ready MonDReg 0x%0h expected none", MonDReg);
        end else begin
          e = exp_mon_q.pop_front();
          check("MonDReg", MonDReg, e);
        end
      end
      rdy_prev = monitor_ready;
    end
  end

  function automatic logic [37:0] jdo_a(input logic [AW-1:0] addr, input logic rd);
    logic [37:0] d;
    d = 38'({$urandom(), $urandom()});
    d[35] = rd;
    d[24:17] = addr;
    return d;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [DW-1:0] data);
    logic [37:0] d;
    d = 38'({$urandom(), $urandom()});
    d[34:3] = data;
    return d;
  endfunction

  // One-cycle strobe pulse; returns at the start of the cycle after the sampling edge.
  task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] d);
    @(posedge clk); #1;
    jdo = d; ta_a = a; ta_b = b; tna_a = na;
    @(posedge clk); #1;
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
  endtask

  task automatic wait_jtag(input string nm, output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (monitor_ready && !jtag_busy) return;
    end
    checks++; errors++;
    $display("FAIL %s_timeout: got no completion expected completion within 30 cycles", nm);
  endtask

  task automatic jtag_read(input logic [AW-1:0] addr, output int n);
    m_mon = ref_mem[addr];
    m_jaddr = addr + 8'd1;
    exp_mon_q.push_back(m_mon);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, 1'b1));
    wait_jtag("jtag_read", n);
  endtask

  task automatic jtag_setaddr(input logic [AW-1:0] addr);
    m_jaddr = addr;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(addr, 1'b0));
  endtask

  task automatic jtag_write(input logic [DW-1:0] data);
    int n;
    ref_mem[m_jaddr] = data;
    m_jaddr = m_jaddr + 8'd1;
    exp_mon_q.push_back(m_mon);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(data));
    wait_jtag("jtag_write", n);
  endtask

  task automatic av_op(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       output int waits);
    bit ok;
    @(posedge clk); #1;
    av_address = addr; av_writedata = data; av_write = wr; av_read = !wr;
    if (wr) ref_mem[addr] = data;
    else exp_av_q.push_back(ref_mem[addr]);
    waits = 0; ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!av_waitrequest) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL av_timeout: got waitrequest stuck expected accept within 30 cycles");
    end
    @(posedge clk); #1;
    av_read = 1'b0; av_write = 1'b0;
  endtask

  // JTAG read and Avalon read both present in the same IDLE cycle.
  task automatic tie(input logic [AW-1:0] ja, input logic [AW-1:0] aa,
                     output int waits, output bit jfirst);
    int n;
    bit ok;
    repeat (2) @(posedge clk);
    m_mon = ref_mem[ja];
    m_jaddr = ja + 8'd1;
    exp_mon_q.push_back(m_mon);
    @(posedge clk); #1;
    jdo = jdo_a(ja, 1'b1); ta_a = 1'b1;
    @(posedge clk); #1;
    ta_a = 1'b0;
    av_read = 1'b1; av_address = aa;
    exp_av_q.push_back(ref_mem[aa]);
    waits = 0; jfirst = 1'b0; ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (monitor_ready) jfirst = 1'b1;
      if (!av_waitrequest) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL tie_timeout: got waitrequest stuck expected accept");
    end
    @(posedge clk); #1;
    av_read = 1'b0;
    wait_jtag("tie", n);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got simulation still running expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n, w;
    bit jf;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] v;
    int wrong_wr;

    for (int i = 0; i < 256; i++) begin
      v = $urandom();
      mem[i] = v;
      ref_mem[i] = v;
    end
    m_jaddr = '0; m_mon = '0;
    jdo = '0; ta_a = 0; ta_b = 0; tna_a = 0;
    av_address = '0; av_read = 0; av_write = 0; av_writedata = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_monitor_ready", monitor_ready, 1'b0);
    check("rst_monitor_error", monitor_error, 1'b0);
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_readdatavalid", av_readdatavalid, 1'b0);
    check("rst_ram_wren", ram_wren, 1'b0);
    check("rst_jtag_busy", jtag_busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // T1: uncontended JTAG read, result visible in cycle 4.
    av_op(1'b1, 8'h10, 32'hDEADBEEF, w);
    jtag_read(8'h10, n);
    check("t1_ready_cycle", n, 4);
    check("t1_monitor_ready", monitor_ready, 1'b1);
    jtag_write(32'h11111111);          // lands at the auto-incremented address 0x11
    av_op(1'b0, 8'h11, '0, w);
    av_op(1'b0, 8'h10, '0, w);

    // T2: JTAG write at 0xFF, address wraps to 0x00.
    jtag_setaddr(8'hFF);
    jtag_write(32'h12345678);
    check("t2_monitor_ready", monitor_ready, 1'b1);
    jtag_write(32'hCAFEF00D);
    av_op(1'b0, 8'hFF, '0, w);
    av_op(1'b0, 8'h00, '0, w);

    // T3: ties alternate. CPU was granted last, so JTAG wins; the CPU then waits through
    // the tie cycle, J_ACC, J_CAP and the return to IDLE.
    tie(8'h50, 8'h60, w, jf);
    check("t3_jtag_first", jf, 1'b1);
    check("t3_cpu_wait", w, 4);
    jtag_write(32'h0BADCAFE);          // JTAG now owned the RAM last
    tie(8'h52, 8'h61, w, jf);
    check("t3b_cpu_first", jf, 1'b0);
    check("t3b_cpu_wait", w, 1);
    tie(8'h53, 8'h62, w, jf);
    check("t3c_cpu_first", jf, 1'b0);

    // T4: overrun drops the second write and raises monitor_error.
    jtag_setaddr(8'h40);
    ref_mem[8'h40] = 32'hAAAA0001;
    m_jaddr = 8'h41;
    exp_mon_q.push_back(m_mon);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'hAAAA0001));
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'hBBBB0002));
    wait_jtag("t4", n);
    check("t4_error_set", monitor_error, 1'b1);
    av_op(1'b0, 8'h40, '0, w);
    av_op(1'b0, 8'h41, '0, w);
    jtag_write(32'hCCCC0003);          // pointer unaffected by the dropped command
    av_op(1'b0, 8'h41, '0, w);
    ref_mem[m_jaddr] = 32'hDDDD0004;
    m_jaddr = m_jaddr + 8'd1;
    exp_mon_q.push_back(m_mon);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'hDDDD0004));
    pulse(1'b0, 1'b1, 1'b1, jdo_b(32'hEEEE0005));
    wait_jtag("t4b", n);
    check("t4_set_wins", monitor_error, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, '0);
    @(negedge clk);
    check("t4_error_clear", monitor_error, 1'b0);
    av_op(1'b0, 8'h42, '0, w);

    // T5: reset asserted while the JTAG read is in J_CAP.
    av_op(1'b1, 8'h30, 32'hA5A50001, w);
    jtag_read(8'h30, n);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h31, 1'b1));
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    exp_mon_q.delete();
    m_mon = '0; m_jaddr = '0;
    #1;
    check("t5_monitor_ready", monitor_ready, 1'b0);
    check("t5_MonDReg", MonDReg, 32'h0);
    check("t5_jtag_busy", jtag_busy, 1'b0);
    check("t5_ram_wren", ram_wren, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wrong_wr = 0;
    repeat (6) begin
      @(negedge clk);
      if (ram_wren) wrong_wr++;
    end
    check("t5_no_write_after", wrong_wr, 0);
    check("t5_MonDReg_after", MonDReg, 32'h0);
    check("t5_ready_after", monitor_ready, 1'b0);

    // T6: back-to-back Avalon writes, two cycles each.
    @(posedge clk); #1;
    av_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      av_address = 8'(i + 1);
      av_writedata = 32'h600D0000 + 32'(i);
      ref_mem[i + 1] = av_writedata;
      n = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        n++;
        if (!av_waitrequest) break;
      end
      check("t6_cycles_per_write", n, 2);
      @(posedge clk); #1;
    end
    av_write = 1'b0;
    for (int i = 1; i <= 4; i++) av_op(1'b0, 8'(i), '0, w);

    // Randomized mix of traffic, including concurrent JTAG and CPU reads.
    for (int t = 0; t < 60; t++) begin
      a1 = 8'($urandom());
      a2 = 8'($urandom());
      case ($urandom_range(0, 4))
        0: av_op(1'b1, a1, $urandom(), w);
        1: av_op(1'b0, a1, '0, w);
        2: jtag_read(a1, n);
        3: begin
          if ($urandom_range(0, 1) == 1) jtag_setaddr(a1);
          jtag_write($urandom());
        end
        default: begin
          a2 = a1 ^ 8'h80;
          fork
            jtag_read(a1, n);
            av_op(1'b0, a2, '0, w);
          join
        end
      endcase
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_av_q.size() != 0 || exp_mon_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d av and %0d jtag responses outstanding expected 0",
               exp_av_q.size(), exp_mon_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
